// File: rtl/shift_deserializer_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receive path.
package shift_deserializer_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } des_state_e;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words LSB- or MSB-first and
// hands them downstream through a one-entry valid/ready holding register.
//
// state | meaning
// IDLE  | no partial word, bit_cnt = 0
// SHIFT | partial word in progress, bit_cnt in 1..WIDTH-1
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             flush,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    des_state_e       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             handshake;

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        ovr_d     = ovr_q;
        handshake = vld_q & dout_ready;

        // Direction is taken live on bit 0 and from the latch for the rest of the word.
        eff_dir = (cnt_q == '0) ? dir : dir_q;
        if (eff_dir == DIR_MSB_FIRST) begin
            shifted = {sreg_q[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, sreg_q[WIDTH-1:1]};
        end

        if (handshake) begin
            vld_d = 1'b0;
        end
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (flush) begin
            cnt_d   = '0;
            sreg_d  = '0;
            state_d = IDLE;
        end else if (sin_valid) begin
            sreg_d = shifted;
            if (cnt_q == '0) begin
                dir_d = dir;
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d   = '0;
                state_d = IDLE;
                // A word completing while the consumer drains the old one replaces it.
                if (!vld_q || handshake) begin
                    dout_d = shifted;
                    vld_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign busy       = (state_q == SHIFT);
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: vector table plus directed corner sequences.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       clr;
    logic       sin;
    logic       sin_valid;
    logic       dir;
    logic       flush;
    logic       clr_ovr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic [3:0] bit_cnt;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       d;
        logic [7:0] stream;  // bit i is the i-th bit sent on sin
        logic [7:0] exp;
        logic       gap;
    } vec_t;

    vec_t vecs[6];

    shift_deserializer #(.WIDTH(8), .CW(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dir        (dir),
        .flush      (flush),
        .clr_ovr    (clr_ovr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_front(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: act=0x%0h exp=<empty scoreboard>", name, dout);
        end else begin
            check(name, dout, exp_q[0]);
        end
    endtask

    task automatic send_bits(input logic d, input logic [7:0] stream, input int n,
                             input int toggle_at, input logic rdy_last,
                             input logic cov_last, input logic gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gap && i == 3) begin
                sin_valid = 1'b0;
                check("gap_cnt_before", bit_cnt, 3);
                @(negedge clk);
                check("gap_cnt_hold", bit_cnt, 3);
                check("gap_busy", busy, 1);
            end
            sin        = stream[i];
            sin_valid  = 1'b1;
            dir        = (toggle_at >= 0 && i >= toggle_at) ? ~d : d;
            dout_ready = rdy_last && (i == n - 1);
            clr_ovr    = cov_last && (i == n - 1);
        end
        @(negedge clk);
        sin_valid  = 1'b0;
        dout_ready = 1'b0;
        clr_ovr    = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("consume_valid", dout_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h4D, 8'h4D, 1'b0};
        vecs[1] = '{1'b1, 8'h4D, 8'hB2, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{1'b0, 8'h80, 8'h80, 1'b1};
        vecs[5] = '{1'b1, 8'hF0, 8'h0F, 1'b0};

        clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0;
        flush = 1'b0; clr_ovr = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", bit_cnt, 0);
        check("rst_ovr", overrun, 0);

        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].d, vecs[v].stream, 8, -1, 1'b0, 1'b0, vecs[v].gap);
            exp_q.push_back(vecs[v].exp);
            check("vec_valid", dout_valid, 1);
            check("vec_busy", busy, 0);
            check("vec_cnt", bit_cnt, 0);
            check_front("vec_dout");
            consume();
            check("vec_dout_hold", dout, vecs[v].exp);
        end

        // dir changes mid-word must not affect the word in progress
        send_bits(1'b1, 8'h4D, 8, 3, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'hB2);
        check_front("dir_toggle_dout");
        consume();

        // Overrun: full holding register drops the second word
        send_bits(1'b0, 8'h4D, 8, -1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h4D);
        check("ovr_pre", overrun, 0);
        send_bits(1'b0, 8'hFF, 8, -1, 1'b0, 1'b0, 1'b0);
        check_front("ovr_dout_kept");
        check("ovr_set", overrun, 1);
        check("ovr_valid", dout_valid, 1);
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        check("ovr_cleared", overrun, 0);
        send_bits(1'b0, 8'hFF, 8, -1, 1'b0, 1'b1, 1'b0);
        check("ovr_set_wins", overrun, 1);
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        check("ovr_cleared2", overrun, 0);

        // Consume and complete on the same edge
        check_front("sim_pre_dout");
        send_bits(1'b1, 8'h4D, 8, -1, 1'b1, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'hB2);
        check_front("sim_dout");
        check("sim_valid", dout_valid, 1);
        check("sim_ovr", overrun, 0);

        // Flush mid-word, holding register untouched
        send_bits(1'b0, 8'h1F, 5, -1, 1'b0, 1'b0, 1'b0);
        check("flush_pre_cnt", bit_cnt, 5);
        check("flush_pre_busy", busy, 1);
        @(negedge clk);
        sin = 1'b1; sin_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        sin_valid = 1'b0; flush = 1'b0;
        check("flush_cnt", bit_cnt, 0);
        check("flush_busy", busy, 0);
        check("flush_valid", dout_valid, 1);
        check_front("flush_dout");
        consume();
        send_bits(1'b0, 8'hF0, 8, -1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'hF0);
        check_front("post_flush_dout");
        check("post_flush_valid", dout_valid, 1);

        // Asynchronous reset between edges, mid-word
        send_bits(1'b0, 8'h07, 3, -1, 1'b0, 1'b0, 1'b0);
        check("mid_cnt", bit_cnt, 3);
        #2 clr = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_cnt", bit_cnt, 0);
        check("arst_ovr", overrun, 0);
        exp_q.delete();
        @(negedge clk);
        clr = 1'b1;
        send_bits(1'b1, 8'h4D, 8, -1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'hB2);
        check_front("after_rst_dout");
        check("after_rst_valid", dout_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive end of the team's serial shift path: collects a serial bit stream produced by a shifting transmitter and assembles it into a parallel word.
- Supports LSB-first or MSB-first assembly, matching the transmitter's right-shift or left-shift direction.
- Completed words wait in a one-entry holding register and are handed downstream with a valid/ready handshake.
- Sits between a serial line driver and the word-level datapath.

Parameters:
- WIDTH, 8: bits per assembled word. Must be at least 2.
- CW, 4: bit-counter width. Must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  asynchronous active-low reset; clears all state immediately while low.
- sin  in  1  serial data bit.
- sin_valid  in  1  the current sin bit is sampled at this edge.
- dir  in  1  0 = LSB-first (shift right, new bit enters the MSB); 1 = MSB-first (shift left, new bit enters the LSB).
- flush  in  1  synchronous abort of the partial word.
- clr_ovr  in  1  synchronous clear of the overrun flag.
- dout  out  WIDTH  holding register contents.
- dout_valid  out  1  holding register holds an unconsumed word.
- dout_ready  in  1  downstream accepts dout this edge.
- busy  out  1  partial word in progress (state SHIFT).
- bit_cnt  out  CW  number of bits collected so far in the partial word.
- overrun  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (clr=0, asynchronous):
  - Shift register, dout, bit_cnt and the latched direction go to 0.
  - dout_valid, busy and overrun go to 0; state goes to IDLE.
- States:
  - IDLE: bit_cnt=0, no partial word.
  - SHIFT: bit_cnt in 1..WIDTH-1.
  - The holding-register full flag is independent of the state and is visible as dout_valid.
- Direction:
  - dir is latched on the edge that samples bit 0 of a word.
  - Changes to dir while in SHIFT are ignored until the next word starts.
- Sampling (sin_valid=1, flush=0):
  - Right mode: sreg = {sin, sreg[WIDTH-1:1]}.
  - Left mode: sreg = {sreg[WIDTH-2:0], sin}.
  - bit_cnt increments by 1. IDLE -> SHIFT on the first bit.
- sin_valid=0: shift register and bit_cnt hold.
- Completion (the sampled bit is bit WIDTH-1):
  - The word formed including that bit is evaluated at the same edge.
  - If the holding register is empty, or dout_valid and dout_ready are both 1 at this edge: dout <= assembled word and dout_valid <= 1.
  - Latency: dout_valid rises in the cycle after the last bit's edge.
  - Otherwise (holding register full, not consumed): the word is discarded, dout is unchanged, overrun <= 1.
  - In both cases bit_cnt <= 0 and state returns to IDLE.
  - Back-to-back words with no idle bit are supported.
- Handshake:
  - dout is stable while dout_valid=1 and no handshake occurs.
  - dout_valid and dout_ready both 1 with no completion at that edge: dout_valid <= 0 and dout holds its last value.
  - dout_ready is ignored when dout_valid=0.
- flush=1:
  - bit_cnt <= 0, state <= IDLE, the shift register contents are discarded.
  - flush has priority over sin_valid at the same edge; that bit is lost.
  - The holding register, dout_valid and overrun are unaffected.
- Overrun:
  - overrun stays set until clr_ovr=1 or reset.
  - If clr_ovr and a new overrun occur at the same edge, overrun stays 1 (set wins).
- busy = (state == SHIFT).
- bit_cnt never reaches WIDTH: it wraps to 0 on completion.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - Direction constants: DIR_LSB_FIRST=0, DIR_MSB_FIRST=1.
  - State encoding: IDLE=0, SHIFT=1.
- No sub-module is required; the shift register, counter and holding register fit in a single module.

Test Plan:
- Reset, then LSB-first: dir=0, stream bits 1,0,1,1,0,0,1,0 one per cycle with dout_ready=0 -> dout=0x4D and dout_valid=1 one cycle after bit 8; busy=0; bit_cnt=0.
- Reset, then MSB-first: dir=1, same bit sequence -> dout=0xB2. Toggling dir after bit 3 leaves the result at 0xB2.
- Overrun:
  - Deliver word 0x4D and hold dout_ready=0.
  - Deliver a second word 0xFF -> dout stays 0x4D and overrun=1.
  - Pulse clr_ovr -> overrun=0.
- Simultaneous consume and complete:
  - dout_valid=1 with dout=0x4D.
  - Raise dout_ready on the same edge as the last bit of 0xB2 -> dout=0xB2, dout_valid stays 1, overrun=0.
- Flush:
  - After 5 bits, assert flush together with sin_valid=1 -> bit_cnt=0, busy=0, dout_valid unchanged.
  - The next 8 bits 0,0,0,0,1,1,1,1 with dir=0 -> dout=0xF0.
- Reset mid-word:
  - Pull clr low asynchronously between edges after 3 bits -> all outputs 0 immediately.
  - After release, a full 8-bit word assembles correctly.
